// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the two-requester FIFO write arbiter.
// State encoding doubles as the one-hot grant vector.
package fifo_wr_arbiter_pkg;

  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/socetlib_fifo.sv
// Synchronous FIFO: write visible at rdata/count one cycle later, rdata is 0 when empty.
// No internal flow control; the caller must never assert WEN when full or REN when empty.
module socetlib_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       WEN,
  input  logic                       REN,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;

  // Explicit wrap keeps DEPTH=1 correct, where the pointer cannot wrap naturally.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (WEN) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (WEN) wptr_q <= bump(wptr_q);
      if (REN) rptr_q <= bump(rptr_q);
      case ({WEN, REN})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign rdata = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular arbiter of two byte requesters into one FIFO; accept-to-visible latency 1 cycle.
// ready is combinational: granted and not full and not clearing; grant holds for the whole packet.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       req0_valid,
  input  logic [7:0]                 req0_data,
  input  logic                       req0_last,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [7:0]                 req1_data,
  input  logic                       req1_last,
  output logic                       req1_ready,
  input  logic                       clear,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  output logic                       rd_empty,
  output logic [$clog2(DEPTH+1)-1:0] rd_count,
  output logic [1:0]                 grant,
  output logic                       rd_underrun
);

  arb_state_t state_q;
  logic       last_served_q;
  logic       underrun_q;
  logic       full;
  logic       acc0;
  logic       acc1;
  logic       wen;
  logic       ren;
  logic [7:0] wdata;

  assign req0_ready = (state_q == GNT0) && !full && !clear;
  assign req1_ready = (state_q == GNT1) && !full && !clear;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign wen        = acc0 || acc1;
  assign wdata      = (state_q == GNT1) ? req1_data : req0_data;
  // A pop on empty only flags underrun; it never gates the write path.
  assign ren        = rd_en && !rd_empty && !clear;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      underrun_q    <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      underrun_q <= 1'b0;
    end else begin
      if (rd_en && rd_empty) underrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (req0_valid && req1_valid) state_q <= last_served_q ? GNT0 : GNT1;
          else if (req0_valid)          state_q <= GNT0;
          else if (req1_valid)          state_q <= GNT1;
        end
        GNT0: if (acc0 && req0_last) begin
          state_q       <= IDLE;
          last_served_q <= 1'b0;
        end
        GNT1: if (acc1 && req1_last) begin
          state_q       <= IDLE;
          last_served_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = state_q;
  assign rd_underrun = underrun_q;

  socetlib_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .WEN   (wen),
    .REN   (ren),
    .clear (clear),
    .wdata (wdata),
    .full  (full),
    .empty (rd_empty),
    .count (rd_count),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: fixed vector table, scripted corner sequences, then random traffic
// compared against a queue-based reference model.
module tb_fifo_wr_arbiter;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_last = 1'b0, req1_last = 1'b0;
  logic [7:0]    req0_data = 8'h00, req1_data = 8'h00;
  logic          req0_ready, req1_ready;
  logic          clear = 1'b0, rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_empty, rd_underrun;
  logic [CW-1:0] rd_count;
  logic [1:0]    grant;

  always #5 CLK = ~CLK;

  fifo_wr_arbiter #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .clear(clear), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_count(rd_count), .grant(grant), .rd_underrun(rd_underrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Reference model: FIFO contents as a queue, owner -1 means nobody holds the grant.
  logic [7:0] mq[$];
  int         owner;
  int         last_srv;
  bit         m_und;

  task automatic model_reset();
    mq.delete();
    owner    = -1;
    last_srv = 1;
    m_und    = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, then advance the model.
  task automatic cyc(input bit c, input bit v0, input bit v1, input logic [7:0] d0,
                     input logic [7:0] d1, input bit l0, input bit l1, input bit re);
    int sz;
    bit r0e, r1e, a0, a1;
    clear = c; req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    req0_last = l0; req1_last = l1; rd_en = re;
    #3;
    sz  = mq.size();
    r0e = (owner == 0) && (sz < DEPTH) && !c;
    r1e = (owner == 1) && (sz < DEPTH) && !c;
    chk("ready0", 32'(req0_ready), 32'(r0e));
    chk("ready1", 32'(req1_ready), 32'(r1e));
    chk("grant", 32'(grant), (owner == 0) ? 1 : (owner == 1) ? 2 : 0);
    chk("rd_count", 32'(rd_count), sz);
    chk("rd_empty", 32'(rd_empty), 32'(sz == 0));
    chk("rd_data", 32'(rd_data), (sz > 0) ? 32'(mq[0]) : 0);
    chk("rd_underrun", 32'(rd_underrun), 32'(m_und));
    @(posedge CLK);
    if (c) begin
      mq.delete();
      owner = -1;
      m_und = 1'b0;
    end else begin
      a0 = v0 && r0e;
      a1 = v1 && r1e;
      if (re && sz == 0) m_und = 1'b1;
      if (re && sz > 0) void'(mq.pop_front());
      if (a0) mq.push_back(d0);
      if (a1) mq.push_back(d1);
      if (owner == -1) begin
        if (v0 && v1) owner = (last_srv == 1) ? 0 : 1;
        else if (v0)  owner = 0;
        else if (v1)  owner = 1;
      end else if (a0 && l0) begin
        owner = -1; last_srv = 0;
      end else if (a1 && l1) begin
        owner = -1; last_srv = 1;
      end
    end
    #1;
  endtask

  typedef struct {
    bit         c, v0, v1, l0, l1, re;
    logic [7:0] d0, d1;
    bit         er0, er1;
    logic [1:0] eg;
    int         ecnt;
    logic [7:0] edat;
    bit         eund;
  } vec_t;

  function automatic vec_t mk(input bit c, input bit v0, input bit v1, input logic [7:0] d0,
                              input logic [7:0] d1, input bit l0, input bit l1, input bit re,
                              input bit er0, input bit er1, input logic [1:0] eg, input int ecnt,
                              input logic [7:0] edat, input bit eund);
    vec_t v;
    v.c = c; v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.l0 = l0; v.l1 = l1; v.re = re;
    v.er0 = er0; v.er1 = er1; v.eg = eg; v.ecnt = ecnt; v.edat = edat; v.eund = eund;
    return v;
  endfunction

  vec_t vt[13];
  bit   rc, rv0, rv1, rl0, rl1, rre;

  initial begin
    // Outputs during reset
    #3;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_count", 32'(rd_count), 0);
    chk("rst_empty", 32'(rd_empty), 1);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_underrun", 32'(rd_underrun), 0);
    #9 nRST = 1'b1;
    @(posedge CLK); #1;

    // Single packet A1..A3 from req0, drain, then empty pop with concurrent write, then clear.
    vt[0]  = mk(0,1,0,8'hA1,8'h00,0,0,0, 0,0,2'b00,0,8'h00,0);
    vt[1]  = mk(0,1,0,8'hA1,8'h00,0,0,0, 1,0,2'b01,0,8'h00,0);
    vt[2]  = mk(0,1,0,8'hA2,8'h00,0,0,0, 1,0,2'b01,1,8'hA1,0);
    vt[3]  = mk(0,1,0,8'hA3,8'h00,1,0,0, 1,0,2'b01,2,8'hA1,0);
    vt[4]  = mk(0,0,0,8'h00,8'h00,0,0,0, 0,0,2'b00,3,8'hA1,0);
    vt[5]  = mk(0,0,0,8'h00,8'h00,0,0,1, 0,0,2'b00,3,8'hA1,0);
    vt[6]  = mk(0,0,0,8'h00,8'h00,0,0,1, 0,0,2'b00,2,8'hA2,0);
    vt[7]  = mk(0,0,0,8'h00,8'h00,0,0,1, 0,0,2'b00,1,8'hA3,0);
    vt[8]  = mk(0,0,1,8'h00,8'h5A,0,0,0, 0,0,2'b00,0,8'h00,0);
    vt[9]  = mk(0,0,1,8'h00,8'h5A,0,1,1, 0,1,2'b10,0,8'h00,0);
    vt[10] = mk(0,0,0,8'h00,8'h00,0,0,0, 0,0,2'b00,1,8'h5A,1);
    vt[11] = mk(1,1,0,8'hEE,8'h00,0,0,1, 0,0,2'b00,1,8'h5A,1);
    vt[12] = mk(0,0,0,8'h00,8'h00,0,0,0, 0,0,2'b00,0,8'h00,0);
    foreach (vt[i]) begin
      clear = vt[i].c; req0_valid = vt[i].v0; req1_valid = vt[i].v1;
      req0_data = vt[i].d0; req1_data = vt[i].d1; req0_last = vt[i].l0;
      req1_last = vt[i].l1; rd_en = vt[i].re;
      #3;
      chk($sformatf("v%0d_ready0", i), 32'(req0_ready), 32'(vt[i].er0));
      chk($sformatf("v%0d_ready1", i), 32'(req1_ready), 32'(vt[i].er1));
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vt[i].eg));
      chk($sformatf("v%0d_count", i), 32'(rd_count), vt[i].ecnt);
      chk($sformatf("v%0d_empty", i), 32'(rd_empty), 32'(vt[i].ecnt == 0));
      chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(vt[i].edat));
      chk($sformatf("v%0d_underrun", i), 32'(rd_underrun), 32'(vt[i].eund));
      @(posedge CLK); #1;
    end
    model_reset();

    // Contention: req0 first, one bubble, then req1 wins the next contention.
    cyc(0,1,1,8'hB0,8'hC0,0,0,0);
    chk("contend_first_grant", 32'(grant), 1);
    cyc(0,1,1,8'hB0,8'hC0,0,0,0);
    cyc(0,1,1,8'hB1,8'hC0,1,0,0);
    chk("bubble_grant", 32'(grant), 0);
    cyc(0,1,1,8'hB2,8'hC0,0,0,0);
    chk("contend_second_grant", 32'(grant), 2);
    cyc(0,1,1,8'hB2,8'hC0,0,1,0);
    repeat (3) cyc(0,0,0,8'h00,8'h00,0,0,1);

    // Full: req1 streams without pops; one pop lets the 9th byte in on the following cycle.
    cyc(0,0,1,8'h00,8'h00,0,0,0);
    for (int b = 0; b < 8; b++) cyc(0,0,1,8'h00,8'(b),0,0,0);
    chk("full_count", 32'(rd_count), 8);
    chk("full_ready", 32'(req1_ready), 0);
    cyc(0,0,1,8'h00,8'h08,0,0,0);
    chk("full_grant_hold", 32'(grant), 2);
    cyc(0,0,1,8'h00,8'h08,0,0,1);
    chk("pop_when_full_count", 32'(rd_count), 7);
    cyc(0,0,1,8'h00,8'h08,0,0,0);
    chk("ninth_accepted_count", 32'(rd_count), 8);
    cyc(0,0,1,8'h00,8'h09,0,1,0);
    cyc(1,0,1,8'h00,8'h09,0,1,0);

    // Clear mid-packet with 4 bytes queued and underrun already set.
    cyc(0,0,0,8'h00,8'h00,0,0,1);
    cyc(0,1,0,8'hD0,8'h00,0,0,0);
    for (int b = 0; b < 4; b++) cyc(0,1,0,8'hD0 + 8'(b),8'h00,0,0,0);
    cyc(1,1,0,8'hEE,8'h00,0,0,1);
    chk("clear_count", 32'(rd_count), 0);
    chk("clear_grant", 32'(grant), 0);
    chk("clear_underrun", 32'(rd_underrun), 0);
    cyc(0,0,0,8'h00,8'h00,0,0,0);

    // Asynchronous reset pulse mid-packet, away from clock edges.
    cyc(0,1,1,8'hF0,8'h00,0,0,0);
    cyc(0,1,0,8'hF0,8'h00,0,0,0);
    cyc(0,1,0,8'hF1,8'h00,0,0,0);
    #3 nRST = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 0);
    chk("arst_ready0", 32'(req0_ready), 0);
    chk("arst_count", 32'(rd_count), 0);
    chk("arst_empty", 32'(rd_empty), 1);
    chk("arst_data", 32'(rd_data), 0);
    chk("arst_underrun", 32'(rd_underrun), 0);
    req0_valid = 1'b0; req1_valid = 1'b0; rd_en = 1'b0; clear = 1'b0;
    #13 nRST = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    cyc(0,0,1,8'h00,8'h77,0,1,0);
    cyc(0,0,1,8'h00,8'h77,0,1,0);
    cyc(0,0,0,8'h00,8'h00,0,0,1);
    cyc(0,0,0,8'h00,8'h00,0,0,0);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rc  = ($urandom_range(0, 39) == 0);
      rv0 = ($urandom_range(0, 3) != 0);
      rv1 = ($urandom_range(0, 3) != 0);
      rl0 = ($urandom_range(0, 3) == 0);
      rl1 = ($urandom_range(0, 3) == 0);
      rre = ($urandom_range(0, 2) == 0);
      cyc(rc, rv0, rv1, 8'($urandom), 8'($urandom), rl0, rl1, rre);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries; it must be a power of 2 and at least 1.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports reqN_valid, input, 1 bit (N=0,1): requester N offers a byte.
REQ-005 The block SHALL have ports reqN_data, input, 8 bits: requester N byte.
REQ-006 The block SHALL have ports reqN_last, input, 1 bit: the offered byte ends requester N's packet.
REQ-007 The block SHALL have ports reqN_ready, output, 1 bit: the byte is accepted this cycle when reqN_valid and reqN_ready are both high.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous flush.
REQ-009 The block SHALL have port rd_en, input, 1 bit: consumer pop request.
REQ-010 The block SHALL have port rd_data, output, 8 bits: FIFO head byte.
REQ-011 The block SHALL have port rd_empty, output, 1 bit: FIFO empty.
REQ-012 The block SHALL have port rd_count, output, $clog2(DEPTH+1) bits: FIFO occupancy.
REQ-013 The block SHALL have port grant, output, 2 bits, one-hot or zero: the current owner.
REQ-014 The block SHALL have port rd_underrun, output, 1 bit: sticky flag for a pop on empty.

Function
REQ-015 The FSM SHALL have states IDLE, GNT0 and GNT1; grant is 00 in IDLE, 01 in GNT0 and 10 in GNT1.
REQ-016 In IDLE with exactly one reqN_valid high, the FSM SHALL enter GNTN on the next edge.
REQ-017 In IDLE with both valids high, the FSM SHALL enter the GNT state of the requester not in last_served; last_served resets to 1, so requester 0 wins first.
REQ-018 reqN_ready SHALL equal (state==GNTN) && !full, combinationally; the non-granted ready SHALL be 0.
REQ-019 Byte acceptance SHALL drive the FIFO write enable with reqN_data in the same cycle; a written byte is visible at rd_data/rd_count one cycle later.
REQ-020 Acceptance of a byte with reqN_last=1 SHALL move GNTN to IDLE and set last_served=N; this costs exactly one idle bubble cycle between packets.
REQ-021 While granted, the grant SHALL hold regardless of valid gaps or full; packets from the two requesters are never interleaved.
REQ-022 The FIFO read enable SHALL be rd_en && !rd_empty; rd_en while rd_empty SHALL set rd_underrun and SHALL NOT block a same-cycle write.
REQ-023 The FIFO write enable SHALL never assert while full, so the FIFO overrun condition is unreachable.
REQ-024 Simultaneous accept and pop when 0<count<DEPTH SHALL leave rd_count unchanged.
REQ-025 Simultaneous pop and write-attempt when full: the pop proceeds, ready stays 0 that cycle, and the accept happens on the next cycle.
REQ-026 Pointer wrap-around SHALL be handled by the FIFO; data order is preserved across the wrap.
REQ-027 clear SHALL empty the FIFO, force the FSM to IDLE, clear rd_underrun and deassert both readys in that cycle; last_served SHALL be preserved.
REQ-028 clear SHALL take priority over every simultaneous accept or pop, and a byte presented in the clear cycle SHALL be dropped.

Reset
REQ-029 nRST low SHALL asynchronously force state=IDLE, last_served=1, rd_underrun=0 and the FIFO empty (rd_count=0, rd_empty=1, rd_data=0x00).
REQ-030 Reset mid-packet SHALL abandon the packet; after release the block resumes from IDLE with no partial state.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, GNT0, GNT1) and the default DEPTH constant.
REQ-032 Storage SHALL be exactly one instance of the team FIFO sub-module socetlib_fifo, DEPTH passed through, with the arbiter gating WEN/REN around it.

Verification
REQ-033 Single packet: req0 sends A1, A2, A3 with last on A3 -> ready from cycle 2, rd_count=3, pops return A1, A2, A3, grant returns to 00.
REQ-034 Contention: both valid in IDLE after reset -> req0 packet first, then req1; on the next contention req1 wins first.
REQ-035 Full: DEPTH=8, req1 sends 10 bytes with no pops -> ready drops after 8 bytes and grant stays 10; one pop -> the 9th byte is accepted the next cycle.
REQ-036 Empty pop with write: rd_en and accept of 0x5A in the same cycle on empty -> rd_underrun=1 and rd_count=1 with rd_data=0x5A.
REQ-037 clear mid-packet with 4 bytes queued -> rd_count=0, grant=00, rd_underrun=0 the next cycle, and the byte offered in the clear cycle is absent.
REQ-038 Async reset pulse mid-packet, not clock-aligned -> all outputs return to reset values immediately.
